// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RAW = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} mem_fsm_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait sequencer: raises ms for MEM_LAT-1 cycles per memory op,
// then spends one RELEASE cycle so the same op cannot retrigger.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic ms
);

  localparam int CW = $clog2(MEM_LAT) + 1;

  mem_fsm_t        state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ms      = 1'b0;
    // Single-cycle memory never freezes the pipeline.
    if (!rst && MEM_LAT > 1) begin
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            ms      = 1'b1;
            cnt_d   = CW'(MEM_LAT - 2);
            state_d = (MEM_LAT > 2) ? WAIT : RELEASE;
          end
        end
        WAIT: begin
          ms    = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RELEASE;
        end
        RELEASE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall/flush control for the 5-stage RV32I pipeline,
// with free-running stall and redirect-flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_ra0,
  input  logic [REG_AW-1:0] id_ra1,
  input  logic              id_re0,
  input  logic              id_re1,
  input  logic [REG_AW-1:0] ex_ra0,
  input  logic [REG_AW-1:0] ex_ra1,
  input  logic [REG_AW-1:0] ex_wa,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic [REG_AW-1:0] mem_wa,
  input  logic              mem_we,
  input  logic              mem_is_load,
  input  logic              mem_req,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic              wb_we,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              stall_idex,
  output logic              flush_idex,
  output logic              stall_exmem,
  output logic              flush_memwb,
  output logic [1:0]        fwd_sel0,
  output logic [1:0]        fwd_sel1,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush
);

  logic             ms;
  logic             lu;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

  mem_wait_fsm #(.MEM_LAT(MEM_LAT)) u_mwf (
    .clk     (clk),
    .rst     (rst),
    .mem_req (mem_req),
    .ms      (ms)
  );

  // A load in MEM has no data yet, so only ALU results forward from MEM.
  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] ra);
    if (mem_we && !mem_is_load && mem_wa != '0 && mem_wa == ra) return FWD_MEM;
    if (wb_we && wb_wa != '0 && wb_wa == ra)                     return FWD_WB;
    return FWD_RAW;
  endfunction

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_memwb = 1'b0;
    fwd_sel0    = FWD_RAW;
    fwd_sel1    = FWD_RAW;
    lu = ex_is_load && ex_we && ex_wa != '0 &&
         ((id_re0 && id_ra0 == ex_wa) || (id_re1 && id_ra1 == ex_wa));
    if (!rst) begin
      fwd_sel0 = fwd(ex_ra0);
      fwd_sel1 = fwd(ex_ra1);
      // A frozen EX keeps its redirect, so squashes wait for the first unfrozen cycle.
      if (ms) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        flush_memwb = 1'b1;
      end else if (ex_redirect) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (lu) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    end
    cnt_stall_d = cnt_stall_q + CNT_W'(stall_pc);
    cnt_flush_d = cnt_flush_q + CNT_W'(flush_ifid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      cnt_stall_q <= cnt_stall_d;
      cnt_flush_q <= cnt_flush_d;
    end
  end

  assign cnt_stall = cnt_stall_q;
  assign cnt_flush = cnt_flush_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard, forwarding and stall/flush controller for the 5-stage pipelined RV32I core.
- Drives the stall and flush inputs of the four segment registers and the PC, and the EX-stage operand-forwarding mux selects.
- Adds three things the first-generation pipeline lacks: load-use interlock, branch/jump redirect squash, and multi-cycle data-memory wait.
- Keeps free-running stall and flush performance counters for the PDU debug bus.

Parameters:
REG_AW, 5, register address width
MEM_LAT, 1, data-memory latency in cycles (>=1); MEM_LAT-1 freeze cycles per load/store
CNT_W, 32, performance counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
id_ra0  in  REG_AW  rs1 address in ID
id_ra1  in  REG_AW  rs2 address in ID
id_re0  in  1  rs1 read enable in ID
id_re1  in  1  rs2 read enable in ID
ex_ra0  in  REG_AW  rs1 address in EX
ex_ra1  in  REG_AW  rs2 address in EX
ex_wa  in  REG_AW  rd in EX
ex_we  in  1  rf write enable in EX
ex_is_load  in  1  EX instruction writes back memory data
ex_redirect  in  1  taken branch, jal or jalr resolved in EX
mem_wa  in  REG_AW  rd in MEM
mem_we  in  1  rf write enable in MEM
mem_is_load  in  1  MEM instruction is a load
mem_req  in  1  MEM instruction is a load or store
wb_wa  in  REG_AW  rd in WB
wb_we  in  1  rf write enable in WB
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID
flush_ifid  out  1  bubble IF/ID
stall_idex  out  1  hold ID/EX
flush_idex  out  1  bubble ID/EX
stall_exmem  out  1  hold EX/MEM
flush_memwb  out  1  bubble MEM/WB
fwd_sel0  out  2  EX rs1 source: 0 raw, 1 MEM alu result, 2 WB data
fwd_sel1  out  2  EX rs2 source, same encoding
cnt_stall  out  CNT_W  cycles with stall_pc high
cnt_flush  out  CNT_W  redirect squash events

Behaviour:
- Reset: asynchronous, active-high. All stall/flush outputs 0, fwd_sel 0, counters 0, FSM in IDLE.
- Forwarding (combinational, per operand):
  - sel=1 if mem_we && !mem_is_load && mem_wa!=0 && mem_wa==ex_ra.
  - Else sel=2 if wb_we && wb_wa!=0 && wb_wa==ex_ra.
  - Else sel=0. MEM has priority over WB.
- Load-use: lu = ex_is_load && ex_we && ex_wa!=0 && ((id_re0 && id_ra0==ex_wa) || (id_re1 && id_ra1==ex_wa)).
  - Response: stall_pc=stall_ifid=1, flush_idex=1. Costs one bubble.
- Redirect: ex_redirect → flush_ifid=1, flush_idex=1, no stall.
  - Redirect beats lu: if both, stall_pc=stall_ifid=0.
- Memory-wait FSM (states IDLE, WAIT, RELEASE; counter width clog2(MEM_LAT)+1):
  - MEM_LAT==1: FSM stays IDLE and ms is never asserted.
  - IDLE && mem_req: ms=1; cnt<=MEM_LAT-2; next WAIT if MEM_LAT>2, else RELEASE.
  - WAIT: ms=1; cnt<=cnt-1; next RELEASE when cnt==1.
  - RELEASE: ms=0; mem_req ignored; next IDLE. This stops the same instruction retriggering.
  - Exactly MEM_LAT-1 freeze cycles per memory op. Back-to-back memory ops each pay the full cost.
- ms override:
  - ms=1 → stall_pc=stall_ifid=stall_idex=stall_exmem=1, flush_memwb=1.
  - All flushes from lu and redirect are suppressed while ms=1. Frozen EX keeps ex_redirect asserted, so it is honoured on the first non-ms cycle.
- Counters:
  - cnt_stall increments on every cycle stall_pc=1.
  - cnt_flush increments on every cycle flush_ifid=1.
  - Both wrap modulo 2^CNT_W.
- rst mid-WAIT: immediate return to IDLE, all outputs 0.

Decomposition:
- hazard_pkg holds:
  - FWD_RAW, FWD_MEM, FWD_WB constants (2-bit).
  - mem_fsm_t enum: IDLE, WAIT, RELEASE.
- Sub-module mem_wait_fsm (parameter MEM_LAT; inputs clk, rst, mem_req; output ms) holds the FSM and down-counter.
- The forwarding, interlock and counter logic stays in hazard_ctrl.

Test Plan:
- Forwarding:
  - ex_ra0=5, mem_wa=5, mem_we=1, mem_is_load=0, wb_wa=5, wb_we=1 → fwd_sel0=1.
  - Same inputs with mem_is_load=1 → fwd_sel0=2.
  - ex_ra0=0 → fwd_sel0=0.
- Load-use: ex_is_load=1, ex_wa=7, id_ra1=7, id_re1=1 → one cycle of stall_pc=stall_ifid=flush_idex=1; cnt_stall=1.
- Redirect plus lu in the same cycle → flush_ifid=flush_idex=1, stall_pc=0; cnt_flush=1.
- MEM_LAT=3, mem_req pulse held while the pipeline is frozen → exactly 2 ms cycles (IDLE→WAIT→RELEASE→IDLE), no third stall. ex_redirect high throughout → flushes appear only in the RELEASE cycle.
- MEM_LAT=1, mem_req=1 every cycle → no stall ever; FSM stays IDLE.
- MEM_LAT=4, rst asserted in the second WAIT cycle → outputs 0 immediately and the FSM is IDLE. A new mem_req after reset produces 3 freeze cycles.
